// File: rtl/dsp_branch_unit.sv
// Registered branch resolver with hardware return-address stack and fixed-length flush.
// Optional statistics counters are enabled by defining DSP_BRANCH_STATS_EN.
module dsp_branch_unit #(
    parameter int WORD_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int MODE_W       = 3,
    parameter int RAS_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MODE_W-1:0] flow_mode,
    input  logic [WORD_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] address,
    input  logic [ADDR_W-1:0] pc_next,
    output logic              jump_flag,
    output logic [ADDR_W-1:0] jump_addr,
    output logic              flush,
    output logic              ras_ovf,
    output logic              ras_unf
`ifdef DSP_BRANCH_STATS_EN
    ,
    output logic [31:0]       br_count,
    output logic [31:0]       taken_count
`endif
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int PTR_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [MODE_W-1:0] MODE_JMP  = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_BEZ  = MODE_W'(2);
    localparam logic [MODE_W-1:0] MODE_BNEZ = MODE_W'(3);
    localparam logic [MODE_W-1:0] MODE_BEQ  = MODE_W'(4);
    localparam logic [MODE_W-1:0] MODE_CALL = MODE_W'(5);
    localparam logic [MODE_W-1:0] MODE_RET  = MODE_W'(6);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    logic [ADDR_W-1:0] stack [RAS_DEPTH];
    logic [PTR_W-1:0]  sp;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;
    logic              stack_full;
    logic              stack_empty;

    logic              accept;
    logic              taken;
    logic [ADDR_W-1:0] target;

    // sp counts occupied entries; the top of stack lives one below it
    assign top_idx     = IDX_W'(sp - PTR_W'(1));
    assign push_idx    = IDX_W'(sp);
    assign stack_full  = (sp == PTR_W'(RAS_DEPTH));
    assign stack_empty = (sp == '0);
    assign accept      = in_valid & in_ready;

    always_comb begin
        taken  = 1'b0;
        target = address;
        case (flow_mode)
            MODE_JMP:  taken = 1'b1;
            MODE_BEZ:  taken = (alu_result == '0);
            MODE_BNEZ: taken = (alu_result != '0);
            MODE_BEQ:  taken = (alu_result == '0);
            MODE_CALL: taken = 1'b1;
            MODE_RET: begin
                taken  = !stack_empty;
                target = stack[top_idx];
            end
            default:   taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // in_ready is gated by rst_n so decode sees the unit as busy throughout reset
    always_comb begin
        state_next = state;
        count_next = count;
        in_ready   = 1'b0;
        flush      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                if (accept && taken) begin
                    state_next = FLUSH;
                    count_next = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (count == '0) begin
                    state_next = IDLE;
                end else begin
                    count_next = count - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_flag <= 1'b0;
            jump_addr <= '0;
        end else begin
            jump_flag <= accept & taken;
            if (accept && taken) begin
                jump_addr <= target;
            end
        end
    end

    // A CALL on a full stack still redirects; only the push is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp      <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (accept) begin
            if (flow_mode == MODE_CALL) begin
                if (stack_full) begin
                    ras_ovf <= 1'b1;
                end else begin
                    stack[push_idx] <= pc_next;
                    sp              <= sp + PTR_W'(1);
                end
            end else if (flow_mode == MODE_RET) begin
                if (stack_empty) begin
                    ras_unf <= 1'b1;
                end else begin
                    sp <= sp - PTR_W'(1);
                end
            end
        end
    end

`ifdef DSP_BRANCH_STATS_EN
    logic is_branch_mode;

    assign is_branch_mode = (flow_mode >= MODE_BEZ) && (flow_mode <= MODE_RET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count    <= '0;
            taken_count <= '0;
        end else if (accept) begin
            if (is_branch_mode && (br_count != 32'hFFFF_FFFF)) begin
                br_count <= br_count + 32'd1;
            end
            if (taken && (taken_count != 32'hFFFF_FFFF)) begin
                taken_count <= taken_count + 32'd1;
            end
        end
    end
`endif

endmodule
